// File: rtl/onehot_req_pkg.sv
// Shared types and helpers for the one-hot request capture front end.
package onehot_req_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_N_REQ           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // Widest request vector the helper below handles; callers zero-extend
  // into it and truncate the result back to their own width.
  localparam int MAX_REQ = 32;

  // Isolate the lowest set bit of vec as a one-hot word (zero in, zero out).
  function automatic logic [MAX_REQ-1:0] lowest_onehot(input logic [MAX_REQ-1:0] vec);
    return vec & (~vec + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/onehot_req_capture_if.sv
// Request-word handshake between the capture stage and the downstream encoder.
interface onehot_req_capture_if
  import onehot_req_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) ();

  logic [N_REQ-1:0] onehot_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output onehot_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  onehot_out,
    input  valid_out,
    output ready_in
  );

endinterface

// File: rtl/onehot_req_capture_debounce.sv
// One request line: two-flop synchroniser, stability counter and debounced
// level. rise_o is combinational so the caller can capture the 0->1 change
// on the same edge that updates the stable level.
module req_debounce
  import onehot_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = sync_q && !stable_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/onehot_req_capture.sv
// Request capture front end: debounces N_REQ raw lines, latches rising edges
// as pending requests and issues them one at a time as held one-hot words.
// Build option: define ONEHOT_REQ_RR_ARB_EN for round-robin arbitration;
// without it the lowest pending index always wins.
//
// state | meaning
// IDLE  | no word on the bus, waiting for a pending request
// HOLD  | word on the bus, held until the consumer takes it
module onehot_req_capture
  import onehot_req_pkg::*;
#(
  parameter int N_REQ           = DEF_N_REQ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [N_REQ-1:0]     req_in,
  onehot_req_capture_if.master bus,
  output logic [N_REQ-1:0]     pending_out,
  output logic                 overflow_out
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;

  logic [N_REQ-1:0] stable_w;
  logic [N_REQ-1:0] rise_w;
  logic [N_REQ-1:0] win_vec;
  logic [N_REQ-1:0] grant_clr;
  logic             grant_en;

  for (genvar g = 0; g < N_REQ; g++) begin : g_line
    req_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .raw_i    (req_in[g]),
      .stable_o (stable_w[g]),
      .rise_o   (rise_w[g])
    );

    // A rise pulse can only mark a line whose debounced level is still low.
    always_comb assert (!(rise_w[g] && stable_w[g]));
  end

`ifdef ONEHOT_REQ_RR_ARB_EN
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, win_idx;

  // Round-robin search starting one past the last granted line.
  always_comb begin : p_arb
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    win_vec = '0;
    win_idx = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && pending_q[idx]) begin
        found        = 1'b1;
        win_idx      = PTR_W'(idx);
        win_vec[idx] = 1'b1;
      end
    end
  end

  // The pointer follows each grant.
  always_comb begin
    ptr_d = grant_en ? win_idx : ptr_q;
  end

  // Last-grant pointer; starting at the top line makes line 0 first after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q <= PTR_W'(N_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    win_vec = N_REQ'(lowest_onehot(MAX_REQ'(pending_q)));
  end
`endif

  // State, issued word, pending set and overflow flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state: leave IDLE on any pending request, leave HOLD once the word
  // is taken and nothing else is waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending_q) state_d = HOLD;
      HOLD:    if (bus.ready_in && !(|pending_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word outputs: load a winner when the bus is free or just consumed,
  // clear when consumed with nothing left, otherwise hold.
  always_comb begin
    onehot_d = onehot_q;
    valid_d  = valid_q;
    grant_en = 1'b0;
    case (state_q)
      IDLE:    grant_en = |pending_q;
      HOLD:    grant_en = bus.ready_in && (|pending_q);
      default: grant_en = 1'b0;
    endcase
    if (grant_en) begin
      onehot_d = win_vec;
      valid_d  = 1'b1;
    end else if (state_q == HOLD && bus.ready_in) begin
      onehot_d = '0;
      valid_d  = 1'b0;
    end
  end

  // Pending set: new rises are OR-ed in after the grant clear, so a rise on
  // the line being granted re-arms it rather than counting as overflow.
  always_comb begin
    grant_clr  = grant_en ? win_vec : '0;
    pending_d  = (pending_q & ~grant_clr) | rise_w;
    overflow_d = |(rise_w & pending_q & ~grant_clr);
  end

  assign bus.onehot_out = onehot_q;
  assign bus.valid_out  = valid_q;
  assign pending_out    = pending_q;
  assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_onehot_req_capture.sv
// Self-checking bench for onehot_req_capture with a behavioural reference model.
module tb_onehot_req_capture;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [N-1:0] req_in;
  logic [N-1:0] pending_out;
  logic         overflow_out;

  onehot_req_capture_if #(.N_REQ(N)) bus ();

  onehot_req_capture #(
    .N_REQ          (N),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .req_in      (req_in),
    .bus         (bus),
    .pending_out (pending_out),
    .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: synchroniser delay, a window of the last DEB synced
  // samples per line, the pending set and the word on the bus.
  logic [N-1:0]   m_s1, m_s2, m_stable, m_pend, m_word;
  logic           m_valid, m_ovf;
  logic [DEB-1:0] m_win [N];
  int             m_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_word = '0;
    m_valid = 1'b0; m_ovf = 1'b0; m_last = N - 1;
    for (int l = 0; l < N; l++) m_win[l] = '0;
  endtask

  function automatic int pick(input logic [N-1:0] p, input int last);
`ifdef ONEHOT_REQ_RR_ARB_EN
    for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
`else
    for (int k = 0; k < N; k++) if (p[k]) return k;
`endif
    return -1;
  endfunction

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic [N-1:0] sync_now;
    logic [N-1:0] rises;
    logic [N-1:0] clr;
    int w;
    sync_now = m_s2;
    rises = '0;
    clr = '0;
    for (int l = 0; l < N; l++) begin
      m_win[l] = {m_win[l][DEB-2:0], sync_now[l]};
      if (m_win[l] == {DEB{~m_stable[l]}}) begin
        if (!m_stable[l]) rises[l] = 1'b1;
        m_stable[l] = ~m_stable[l];
      end
    end
    if (!m_valid || bus.ready_in) begin
      if (m_pend != '0) begin
        w = pick(m_pend, m_last);
        clr[w] = 1'b1;
        m_word = clr;
        m_valid = 1'b1;
        m_last = w;
      end else begin
        m_word = '0;
        m_valid = 1'b0;
      end
    end
    m_ovf  = |(rises & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rises;
    m_s2 = m_s1;
    m_s1 = req_in;
  endtask

  // Called at a falling edge: drive, clock, then compare at the next falling edge.
  task automatic cycle(input logic [N-1:0] r, input logic rdy);
    req_in = r;
    bus.ready_in = rdy;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_eq("valid", {31'd0, bus.valid_out}, {31'd0, m_valid});
    check_eq("onehot", {28'd0, bus.onehot_out}, {28'd0, m_word});
    check_eq("pending", {28'd0, pending_out}, {28'd0, m_pend});
    check_eq("overflow", {31'd0, overflow_out}, {31'd0, m_ovf});
  endtask

  task automatic settle();
    for (int i = 0; i < 2 * DEB + 2; i++) cycle('0, 1'b1);
  endtask

  int           first;
  int           nw;
  int           ovf_cnt;
  int           n8;
  logic [11:0]  words;
  logic [N-1:0] rq;
  int           hold [N];

  initial begin
    rst_n_in = 1'b0;
    req_in = '0;
    bus.ready_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    check_eq("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    check_eq("rst_onehot", {28'd0, bus.onehot_out}, 32'd0);
    check_eq("rst_pending", {28'd0, pending_out}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow_out}, 32'd0);
    rst_n_in = 1'b1;

    // Single request and latency.
    first = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0100, 1'b1);
      if (first < 0 && bus.valid_out) first = i;
    end
    check_eq("single_latency", first, DEB + 2);
    settle();

    // Glitch shorter than the debounce window.
    for (int i = 0; i < 3; i++) cycle(4'b0010, 1'b1);
    for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b1);
    check_eq("glitch_pending", {28'd0, pending_out}, 32'd0);

    // Simultaneous requests.
    nw = 0;
    words = '0;
    for (int i = 0; i < 14; i++) begin
      cycle(4'b1011, 1'b1);
      if (bus.valid_out && nw < 3) begin
        words = {words[7:0], bus.onehot_out};
        nw++;
      end
    end
`ifdef ONEHOT_REQ_RR_ARB_EN
    check_eq("simul_count", nw, 3);
`else
    check_eq("simul_order", {20'd0, words}, 32'h128);
`endif
    settle();

    // Backpressure with a second request arriving while the word is held.
    for (int i = 0; i < DEB + 3; i++) cycle(4'b0001, 1'b0);
    for (int i = 0; i < 10; i++) cycle(4'b0101, 1'b0);
    check_eq("bp_hold_word", {28'd0, bus.onehot_out}, 32'h1);
    check_eq("bp_pending", {28'd0, pending_out}, 32'h4);
    cycle(4'b0101, 1'b1);
    check_eq("bp_next_word", {28'd0, bus.onehot_out}, 32'h4);
    settle();

    // Overflow: line 3 re-rises while its request is still pending.
    ovf_cnt = 0;
    for (int i = 0; i < DEB + 3; i++) cycle(4'b0001, 1'b0);
    for (int i = 0; i < DEB + 3; i++) cycle(4'b1001, 1'b0);
    for (int i = 0; i < 2 * DEB; i++) cycle(4'b0001, 1'b0);
    for (int i = 0; i < 2 * DEB; i++) begin
      cycle(4'b1001, 1'b0);
      if (overflow_out) ovf_cnt++;
    end
    check_eq("ovf_pulses", ovf_cnt, 1);
    check_eq("ovf_pending3", {31'd0, pending_out[3]}, 32'd1);
    n8 = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1001, 1'b1);
      if (bus.valid_out && bus.onehot_out == 4'b1000) n8++;
    end
    check_eq("ovf_words", n8, 1);
    settle();

    // Asynchronous reset while a word is held.
    for (int i = 0; i < DEB + 3; i++) cycle(4'b0001, 1'b0);
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, bus.valid_out}, 32'd0);
    check_eq("arst_onehot", {28'd0, bus.onehot_out}, 32'd0);
    check_eq("arst_pending", {28'd0, pending_out}, 32'd0);
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0001, 1'b1);
      if (first < 0 && bus.valid_out) first = i;
    end
    check_eq("arst_reissue", first, DEB + 2);
    settle();

    // Randomised traffic: mixed glitches and long holds, random backpressure.
    rq = '0;
    for (int l = 0; l < N; l++) hold[l] = $urandom_range(1, 3 * DEB);
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < N; l++) begin
        hold[l]--;
        if (hold[l] == 0) begin
          rq[l] = ~rq[l];
          hold[l] = $urandom_range(1, 3 * DEB);
        end
      end
      cycle(rq, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
